// File: rtl/motoro3_hall_step_decoder_if.sv
// Hall decoder signal bundle: raw Hall inputs in, decoded step/direction/speed and fault flags out.
// The decoder uses the slave modport and the Hall source/consumer uses the master modport.
interface motoro3_hall_step_decoder_if #(
  parameter int CNT_W = 25
);
  logic [2:0]       hallIn;
  logic [3:0]       hsStep;
  logic             hsStepValid;
  logic             hsStepPulse;
  logic             hsDirRev;
  logic [CNT_W-1:0] hsPeriod;
  logic             hsPeriodValid;
  logic             hsStall;
  logic             hsHallErr;
  logic             hsSkipErr;

  modport slave (
    input  hallIn,
    output hsStep, hsStepValid, hsStepPulse, hsDirRev,
    output hsPeriod, hsPeriodValid, hsStall, hsHallErr, hsSkipErr
  );

  modport master (
    output hallIn,
    input  hsStep, hsStepValid, hsStepPulse, hsDirRev,
    input  hsPeriod, hsPeriodValid, hsStall, hsHallErr, hsSkipErr
  );
endinterface

// File: rtl/motoro3_hall_step_decoder.sv
// Hall sensor decoder: synchronizes and debounces {C,B,A}, maps codes to the 6-step index,
// tracks direction, measures step period and flags stall / invalid code / skipped step.
module motoro3_hall_step_decoder #(
  parameter int               DEBOUNCE    = 16,
  parameter int               CNT_W       = 25,
  parameter logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(10000000)
) (
  input  logic                          clk,
  input  logic                          nRst,
  motoro3_hall_step_decoder_if.slave    hs
);

  localparam int               RUN_W   = $clog2(DEBOUNCE + 1);
  localparam logic [RUN_W-1:0] RUN_ACC = RUN_W'(DEBOUNCE - 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEBOUNCE);

  typedef enum logic [1:0] {ST_INIT, ST_ACQ, ST_RUN} state_t;

  function automatic logic code_ok(input logic [2:0] c);
    return (c != 3'b000) && (c != 3'b111);
  endfunction

  function automatic logic [3:0] hall_decode(input logic [2:0] c);
    case (c)
      3'b001:  return 4'd0;
      3'b011:  return 4'd1;
      3'b010:  return 4'd2;
      3'b110:  return 4'd3;
      3'b100:  return 4'd4;
      3'b101:  return 4'd5;
      default: return 4'd0;
    endcase
  endfunction

  // (new - old) mod 6: 1 is a forward step, 5 a reverse step, anything else a skip
  function automatic logic [3:0] step_delta(input logic [3:0] new_s, input logic [3:0] old_s);
    logic [3:0] d;
    d = new_s + 4'd6 - old_s;
    if (d >= 4'd6) d = d - 4'd6;
    return d;
  endfunction

  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]       sync_vld_q, sync_vld_d;
  logic [2:0]       cand_q, cand_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [2:0]       last_code_q, last_code_d;
  logic             last_vld_q, last_vld_d;
  logic             acc_q, acc_d;
  logic [2:0]       acc_code_q, acc_code_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [3:0]       step_q, step_d;
  logic             step_vld_q, step_vld_d;
  logic             pulse_q, pulse_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             per_vld_q, per_vld_d;
  logic             stall_q, stall_d;
  logic             herr_q, herr_d;
  logic             skip_q, skip_d;

  logic [3:0]       new_step;
  logic [3:0]       delta;

  // Synchronizer and debounce filter. The valid shift keeps the post-reset zeros of the
  // synchronizer from ever being treated as a Hall code.
  always_comb begin
    sync1_d     = hs.hallIn;
    sync2_d     = sync1_q;
    sync_vld_d  = {sync_vld_q[0], 1'b1};
    cand_d      = cand_q;
    run_d       = run_q;
    last_code_d = last_code_q;
    last_vld_d  = last_vld_q;
    acc_d       = 1'b0;
    acc_code_d  = acc_code_q;
    if (sync_vld_q[1]) begin
      if ((run_q == '0) || (sync2_q != cand_q)) begin
        cand_d = sync2_q;
        run_d  = RUN_W'(1);
      end else if (run_q == RUN_ACC) begin
        run_d = RUN_MAX;
        if (!last_vld_q || (sync2_q != last_code_q)) begin
          acc_d       = 1'b1;
          acc_code_d  = sync2_q;
          last_code_d = sync2_q;
          last_vld_d  = 1'b1;
        end
      end else if (run_q != RUN_MAX) begin
        run_d = run_q + RUN_W'(1);
      end
    end
  end

  // Step state machine; the period counter holds the cycle count since the last accepted step
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    step_vld_d = step_vld_q;
    pulse_d    = 1'b0;
    dir_d      = dir_q;
    period_d   = period_q;
    per_vld_d  = 1'b0;
    stall_d    = stall_q;
    herr_d     = herr_q;
    skip_d     = 1'b0;
    new_step   = hall_decode(acc_code_q);
    delta      = step_delta(new_step, step_q);

    if (state_q == ST_INIT)            per_cnt_d = '0;
    else if (per_cnt_q != STALL_LIMIT) per_cnt_d = per_cnt_q + CNT_W'(1);
    else                               per_cnt_d = per_cnt_q;

    if (acc_q) begin
      if (!code_ok(acc_code_q)) begin
        herr_d     = 1'b1;
        step_vld_d = 1'b0;
        state_d    = ST_INIT;
        per_cnt_d  = '0;
      end else begin
        step_d     = new_step;
        step_vld_d = 1'b1;
        pulse_d    = 1'b1;
        herr_d     = 1'b0;
        stall_d    = 1'b0;
        per_cnt_d  = CNT_W'(1);
        if (state_q == ST_INIT) begin
          state_d = ST_ACQ;
        end else if ((delta == 4'd1) || (delta == 4'd5)) begin
          if ((state_q == ST_RUN) && ((delta == 4'd5) == dir_q)) begin
            period_d  = per_cnt_q;
            per_vld_d = 1'b1;
          end else begin
            dir_d   = (delta == 4'd5);
            state_d = (state_q == ST_RUN) ? ST_ACQ : ST_RUN;
          end
        end else begin
          skip_d  = 1'b1;
          state_d = ST_ACQ;
        end
      end
    end else if ((state_q != ST_INIT) && (per_cnt_q == STALL_LIMIT) && !stall_q) begin
      stall_d = 1'b1;
      state_d = ST_ACQ;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync_vld_q  <= '0;
      cand_q      <= '0;
      run_q       <= '0;
      last_code_q <= '0;
      last_vld_q  <= 1'b0;
      acc_q       <= 1'b0;
      acc_code_q  <= '0;
      state_q     <= ST_INIT;
      per_cnt_q   <= '0;
      step_q      <= '0;
      step_vld_q  <= 1'b0;
      pulse_q     <= 1'b0;
      dir_q       <= 1'b0;
      period_q    <= '0;
      per_vld_q   <= 1'b0;
      stall_q     <= 1'b0;
      herr_q      <= 1'b0;
      skip_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync_vld_q  <= sync_vld_d;
      cand_q      <= cand_d;
      run_q       <= run_d;
      last_code_q <= last_code_d;
      last_vld_q  <= last_vld_d;
      acc_q       <= acc_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      step_q      <= step_d;
      step_vld_q  <= step_vld_d;
      pulse_q     <= pulse_d;
      dir_q       <= dir_d;
      period_q    <= period_d;
      per_vld_q   <= per_vld_d;
      stall_q     <= stall_d;
      herr_q      <= herr_d;
      skip_q      <= skip_d;
    end
  end

  assign hs.hsStep        = step_q;
  assign hs.hsStepValid   = step_vld_q;
  assign hs.hsStepPulse   = pulse_q;
  assign hs.hsDirRev      = dir_q;
  assign hs.hsPeriod      = period_q;
  assign hs.hsPeriodValid = per_vld_q;
  assign hs.hsStall       = stall_q;
  assign hs.hsHallErr     = herr_q;
  assign hs.hsSkipErr     = skip_q;

endmodule
